// File: rtl/vram_sched_pkg.sv
// Shared constants and types for the VRAM write scheduler.
package vram_sched_pkg;

  localparam int VRAM_ADDR_W = 12;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic {
    FILL_IDLE,
    FILL_RUN
  } fill_state_e;

  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] data;
  } vram_wr_t;

endpackage

// File: rtl/vram_write_scheduler_if.sv
// CPU post / fill command / VRAM port bundle for the write scheduler.
interface vram_write_scheduler_if #(
  parameter int ADDR_W = 12
);
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_data;
  logic              fill_start;
  logic [ADDR_W-1:0] fill_addr;
  logic [ADDR_W:0]   fill_len;
  logic [7:0]        fill_value;
  logic              vram_window;
  logic              clr_overflow;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_data;
  logic              fifo_full;
  logic              busy;
  logic              overflow;

  modport master (
    output cpu_we, cpu_addr, cpu_data, fill_start, fill_addr, fill_len,
           fill_value, vram_window, clr_overflow,
    input  vram_we, vram_addr, vram_data, fifo_full, busy, overflow
  );

  modport slave (
    input  cpu_we, cpu_addr, cpu_data, fill_start, fill_addr, fill_len,
           fill_value, vram_window, clr_overflow,
    output vram_we, vram_addr, vram_data, fifo_full, busy, overflow
  );
endinterface

// File: rtl/vram_write_scheduler_fifo.sv
// Generic synchronous FIFO; push is ignored when full, pop when empty.
module sync_fifo_m #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Full is judged on the pre-edge count, so a pop on the same edge never frees room for a push.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed: contents are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/vram_write_scheduler.sv
// Owns the VRAM write port: drains posted CPU writes during GPU windows,
// and runs a constant-byte fill engine behind them when the FIFO is empty.
module vram_write_scheduler
  import vram_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = VRAM_ADDR_W
) (
  input  logic                   clk_12_5875,
  input  logic                   rst,
  vram_write_scheduler_if.slave  bus
);

  localparam int CW = $clog2(FIFO_DEPTH);

  vram_wr_t          push_wr, head_wr;
  logic              fifo_full, fifo_empty, fifo_pop, fill_issue;
  logic [CW:0]       fifo_count;

  fill_state_e       state, state_nx;
  logic [ADDR_W-1:0] cur_addr, cur_addr_nx;
  logic [ADDR_W:0]   remaining, remaining_nx;
  logic [7:0]        value, value_nx;

  logic              we_q, overflow_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;

  assign push_wr = {bus.cpu_addr, bus.cpu_data};

  sync_fifo_m #(
    .WIDTH ($bits(vram_wr_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_12_5875),
    .rst   (rst),
    .push  (bus.cpu_we),
    .pop   (fifo_pop),
    .wdata (push_wr),
    .rdata (head_wr),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Posted CPU writes always win the window; fill only uses windows the FIFO leaves idle.
  assign fifo_pop   = bus.vram_window & ~fifo_empty;
  assign fill_issue = bus.vram_window & fifo_empty & (state == FILL_RUN);

  // Fill FSM next state: latch a command in IDLE, step address/remaining on each issued fill write.
  always_comb begin
    state_nx     = state;
    cur_addr_nx  = cur_addr;
    remaining_nx = remaining;
    value_nx     = value;
    case (state)
      FILL_IDLE: begin
        if (bus.fill_start) begin
          cur_addr_nx  = bus.fill_addr;
          remaining_nx = bus.fill_len;
          value_nx     = bus.fill_value;
          if (bus.fill_len != '0) state_nx = FILL_RUN;
        end
      end
      FILL_RUN: begin
        if (fill_issue) begin
          cur_addr_nx  = cur_addr + 1'b1;
          remaining_nx = remaining - 1'b1;
          if (remaining == (ADDR_W+1)'(1)) state_nx = FILL_IDLE;
        end
      end
      default: state_nx = FILL_IDLE;
    endcase
  end

  // Fill FSM registers.
  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      state     <= FILL_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      value     <= '0;
    end else begin
      state     <= state_nx;
      cur_addr  <= cur_addr_nx;
      remaining <= remaining_nx;
      value     <= value_nx;
    end
  end

  // Registered VRAM port: strobe for one cycle per issue, address/data hold between writes.
  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q <= fifo_pop | fill_issue;
      if (fifo_pop) begin
        addr_q <= head_wr.addr;
        data_q <= head_wr.data;
      end else if (fill_issue) begin
        addr_q <= cur_addr;
        data_q <= value;
      end
    end
  end

  // Sticky overflow: a dropped push sets it and beats a same-edge clear.
  always_ff @(posedge clk_12_5875) begin
    if (rst)                           overflow_q <= 1'b0;
    else if (bus.cpu_we && fifo_full)  overflow_q <= 1'b1;
    else if (bus.clr_overflow)         overflow_q <= 1'b0;
  end

  assign bus.vram_we   = we_q;
  assign bus.vram_addr = addr_q;
  assign bus.vram_data = data_q;
  assign bus.fifo_full = fifo_full;
  assign bus.overflow  = overflow_q;
  assign bus.busy      = (state == FILL_RUN) | (fifo_count != '0);

endmodule
